gray_conv_arbiter: RTL and testbench

Round-robin arbiter that shares one gray-to-binary converter between NREQ requesters. Each requester offers a gray-coded word over a valid/ready handshake. The arbiter grants one requester per cycle, converts the word through a single gray2bin instance and holds the binary result plus the requester id in a one-entry output register under valid/ready backpressure. It sits in Common, in front of any logic that consumes several gray-coded counters or pointers but has budget for only one converter.

---
 rtl/gca_pkg.sv | 17 +
 rtl/gray2bin.sv | 25 ++
 rtl/rr_pick.sv | 58 +++++
 rtl/gray_conv_arbiter.sv | 106 ++++++++++
 tb/tb_gray_conv_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gca_pkg.sv
// ---------------------------------------------------------------------------
// gca_pkg
// Shared definitions for gray_conv_arbiter and its round-robin picker.
//   id_width()     : width of a requester index, clamped to at least 1 bit so
//                    a single-requester build still has a legal id port.
//   SLOT_RST_BIT   : value every bit of the output slot (valid, data, id)
//                    and the priority pointer takes in reset.
// ---------------------------------------------------------------------------
package gca_pkg;

   function automatic int id_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam logic SLOT_RST_BIT = 1'b0;

endpackage

// File: rtl/gray2bin.sv
// ---------------------------------------------------------------------------
// gray2bin
// Combinational gray-code to binary converter.
//   i_gray [DW-1:0]  gray-coded input word
//   o_bin  [DW-1:0]  binary equivalent; bit i is the XOR of gray bits DW-1..i
// ---------------------------------------------------------------------------
module gray2bin #(
   parameter int DW = 32
) (
   input  logic [DW-1:0] i_gray,
   output logic [DW-1:0] o_bin
);

   // NOTE: every signal written in always_comb gets a default first so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      o_bin = '0;
      for (int i = 0; i < DW; i++) begin
         // Reduction of the shifted word equals the prefix-XOR chain from the
         // MSB, without a bit-serial dependency on o_bin itself.
         o_bin[i] = ^(i_gray >> i);
      end
   end

endmodule

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker.
//   i_req       [NREQ-1:0] request vector
//   i_rr_ptr    [IDW-1:0]  highest-priority index (always < NREQ)
//   i_enable               when low no grant is issued
//   o_grant     [NREQ-1:0] one-hot grant, all zero when nothing is granted
//   o_grant_idx [IDW-1:0]  index of the granted requester
// Scans i_rr_ptr, i_rr_ptr+1, ... wrapping at NREQ-1 (not at 2^IDW-1).
// ---------------------------------------------------------------------------
module rr_pick
   import gca_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDW  = id_width(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_rr_ptr,
   input  logic            i_enable,
   output logic [NREQ-1:0] o_grant,
   output logic [IDW-1:0]  o_grant_idx
);

   logic [2*NREQ-1:0] w_req_dbl;
   logic [NREQ-1:0]   w_req_rot;
   logic [IDW-1:0]    w_offset;
   logic [IDW:0]      w_sum;
   logic              w_any;

   // Doubling the vector turns the wrapping scan into a plain shift: bit j of
   // w_req_rot is requester (rr_ptr + j) mod NREQ.
   assign w_req_dbl = {i_req, i_req};
   assign w_req_rot = NREQ'(w_req_dbl >> i_rr_ptr);
   assign w_any     = i_enable && (|i_req);

   // Lowest set bit of the rotated vector is the distance to the winner.
   always_comb begin
      w_offset = '0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         if (w_req_rot[j]) w_offset = IDW'(j);
      end
   end

   // One extra bit holds ptr+offset before folding back into 0..NREQ-1.
   always_comb begin
      w_sum       = {1'b0, i_rr_ptr} + {1'b0, w_offset};
      o_grant_idx = w_sum[IDW-1:0];
      if (w_sum >= (IDW+1)'(NREQ)) o_grant_idx = IDW'(w_sum - (IDW+1)'(NREQ));
   end

   always_comb begin
      o_grant = '0;
      for (int j = 0; j < NREQ; j++) begin
         o_grant[j] = w_any && (o_grant_idx == IDW'(j));
      end
   end

endmodule

// File: rtl/gray_conv_arbiter.sv
// ---------------------------------------------------------------------------
// gray_conv_arbiter
// Round-robin arbiter sharing one gray-to-binary converter among NREQ
// requesters, with a one-entry output register under valid/ready.
//   clk                         rising-edge clock
//   rst                         synchronous active-high reset
//   req_valid [NREQ-1:0]        per-requester valid
//   req_gray  [NREQ*DW-1:0]     requester k's gray word at [k*DW +: DW]
//   req_ready [NREQ-1:0]        per-requester ready, at most one bit high
//   out_valid                   output slot holds a result
//   out_ready                   downstream accepts the result
//   out_bin   [DW-1:0]          converted binary word
//   out_id    [IDW-1:0]         index of the requester that supplied it
// ---------------------------------------------------------------------------
module gray_conv_arbiter
   import gca_pkg::*;
#(
   parameter  int DW   = 32,
   parameter  int NREQ = 4,
   localparam int IDW  = id_width(NREQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*DW-1:0] req_gray,
   output logic [NREQ-1:0]    req_ready,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DW-1:0]      out_bin,
   output logic [IDW-1:0]     out_id
);

   logic            r_out_valid;
   logic [DW-1:0]   r_out_bin;
   logic [IDW-1:0]  r_out_id;
   logic [IDW-1:0]  r_rr_ptr;

   logic            w_can_load;
   logic            w_pick_en;
   logic            w_xfer;
   logic [NREQ-1:0] w_grant;
   logic [IDW-1:0]  w_grant_idx;
   logic [DW-1:0]   w_sel_gray;
   logic [DW-1:0]   w_sel_bin;

   // The slot may load when empty or when it is being drained this cycle.
   // Reset masks the picker so req_ready stays low for the whole reset.
   assign w_can_load = !r_out_valid || out_ready;
   assign w_pick_en  = w_can_load && !rst;

   rr_pick #(
      .NREQ (NREQ)
   ) u_rr_pick (
      .i_req       (req_valid),
      .i_rr_ptr    (r_rr_ptr),
      .i_enable    (w_pick_en),
      .o_grant     (w_grant),
      .o_grant_idx (w_grant_idx)
   );

   assign req_ready = w_grant;
   assign w_xfer    = |(req_valid & w_grant);

   // Grant is one-hot, so an OR-mux selects the granted word.
   always_comb begin
      w_sel_gray = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (w_grant[k]) w_sel_gray = w_sel_gray | req_gray[k*DW +: DW];
      end
   end

   gray2bin #(
      .DW (DW)
   ) u_gray2bin (
      .i_gray (w_sel_gray),
      .o_bin  (w_sel_bin)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= SLOT_RST_BIT;
         r_out_bin   <= {DW{SLOT_RST_BIT}};
         r_out_id    <= {IDW{SLOT_RST_BIT}};
         r_rr_ptr    <= {IDW{SLOT_RST_BIT}};
      end else begin
         if (w_xfer) begin
            // Covers the simultaneous drain-and-load case: slot stays valid.
            r_out_valid <= 1'b1;
            r_out_bin   <= w_sel_bin;
            r_out_id    <= w_grant_idx;
            r_rr_ptr    <= (w_grant_idx == IDW'(NREQ - 1)) ? '0
                                                           : w_grant_idx + 1'b1;
         end else if (out_ready) begin
            // Data and id are left as-is; only the valid flag drops.
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_bin   = r_out_bin;
   assign out_id    = r_out_id;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gray_conv_arbiter
// Directed bench: dut_a is DW=8/NREQ=4, dut_b is DW=8/NREQ=3 for wrap tests.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_gray_conv_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // dut_a: NREQ=4
   logic        rst;
   logic [3:0]  req_valid, req_ready;
   logic [31:0] req_gray;
   logic        out_valid, out_ready;
   logic [7:0]  out_bin;
   logic [1:0]  out_id;

   // dut_b: NREQ=3
   logic        rst_b;
   logic [2:0]  req_valid_b, req_ready_b;
   logic [23:0] req_gray_b;
   logic        out_valid_b, out_ready_b;
   logic [7:0]  out_bin_b;
   logic [1:0]  out_id_b;

   gray_conv_arbiter #(.DW(8), .NREQ(4)) dut_a (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_gray  (req_gray),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bin   (out_bin),
      .out_id    (out_id)
   );

   gray_conv_arbiter #(.DW(8), .NREQ(3)) dut_b (
      .clk       (clk),
      .rst       (rst_b),
      .req_valid (req_valid_b),
      .req_gray  (req_gray_b),
      .req_ready (req_ready_b),
      .out_valid (out_valid_b),
      .out_ready (out_ready_b),
      .out_bin   (out_bin_b),
      .out_id    (out_id_b)
   );

   task automatic test_reset();
      rst = 1'b1; rst_b = 1'b1;
      req_valid = 4'hF; req_valid_b = 3'h7;
      req_gray = '1; req_gray_b = '1;
      out_ready = 1'b0; out_ready_b = 1'b0;
      #1;
      checks++;
      if (req_ready !== 4'h0) begin
         errors++; $display("FAIL reset_ready_pre_edge: got %b expected 0000", req_ready);
      end
      repeat (2) begin
         @(negedge clk); #1;
         checks++;
         if (req_ready !== 4'h0) begin
            errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
         end
         checks++;
         if ({out_valid, out_id, out_bin} !== 11'h000) begin
            errors++; $display("FAIL reset_slot: got v=%b id=%0d bin=%h expected v=0 id=0 bin=00",
                               out_valid, out_id, out_bin);
         end
         checks++;
         if ({req_ready_b, out_valid_b, out_id_b, out_bin_b} !== 14'h0) begin
            errors++; $display("FAIL reset_b: got rdy=%b v=%b id=%0d bin=%h expected all zero",
                               req_ready_b, out_valid_b, out_id_b, out_bin_b);
         end
      end
      rst = 1'b0; rst_b = 1'b0;
      req_valid = '0; req_valid_b = '0;
      out_ready = 1'b1; out_ready_b = 1'b1;
   endtask

   task automatic test_throughput();
      logic [7:0] exp_bin [4] = '{8'h01, 8'h0A, 8'hFF, 8'h80};
      logic [3:0] exp_rdy;
      @(negedge clk);
      req_gray  = {8'hC0, 8'h80, 8'h0F, 8'h01};
      req_valid = 4'hF;
      #1;
      checks++;
      if ({req_ready, out_valid} !== {4'b0001, 1'b0}) begin
         errors++; $display("FAIL thru_first_grant: got rdy=%b v=%b expected rdy=0001 v=0",
                            req_ready, out_valid);
      end
      for (int t = 1; t <= 4; t++) begin
         @(negedge clk);
         req_valid[t-1] = 1'b0;
         #1;
         exp_rdy = (t < 4) ? 4'(1 << t) : 4'b0000;
         checks++;
         if ({out_valid, out_id, out_bin} !== {1'b1, 2'(t-1), exp_bin[t-1]}) begin
            errors++; $display("FAIL thru_out_%0d: got v=%b id=%0d bin=%h expected v=1 id=%0d bin=%h",
                               t-1, out_valid, out_id, out_bin, t-1, exp_bin[t-1]);
         end
         checks++;
         if (req_ready !== exp_rdy) begin
            errors++; $display("FAIL thru_ready_%0d: got %b expected %b", t, req_ready, exp_rdy);
         end
      end
      @(negedge clk); #1;
      checks++;
      if ({out_valid, out_id, out_bin} !== {1'b0, 2'd3, 8'h80}) begin
         errors++; $display("FAIL thru_drain: got v=%b id=%0d bin=%h expected v=0 id=3 bin=80",
                            out_valid, out_id, out_bin);
      end
   endtask

   task automatic test_backpressure();
      // rr_ptr is 0 here; load requester 2 first.
      @(negedge clk);
      req_gray[23:16] = 8'h80;
      req_valid = 4'b0100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++; $display("FAIL bp_load_ready: got %b expected 0100", req_ready);
      end
      @(negedge clk);
      req_gray[31:24] = 8'hC0;
      req_gray[15:8]  = 8'h0F;
      req_valid = 4'b1010;
      out_ready = 1'b0;
      #1;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) begin @(negedge clk); #1; end
         checks++;
         if ({out_valid, out_id, out_bin} !== {1'b1, 2'd2, 8'hFF}) begin
            errors++; $display("FAIL bp_hold_%0d: got v=%b id=%0d bin=%h expected v=1 id=2 bin=ff",
                               c, out_valid, out_id, out_bin);
         end
         checks++;
         if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL bp_stall_ready_%0d: got %b expected 0000", c, req_ready);
         end
      end
      // Release: pointer still 3, so requester 3 wins over requester 1.
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      checks++;
      if ({req_ready, out_valid, out_id, out_bin} !== {4'b1000, 1'b1, 2'd2, 8'hFF}) begin
         errors++; $display("FAIL bp_release: got rdy=%b v=%b id=%0d bin=%h expected rdy=1000 v=1 id=2 bin=ff",
                            req_ready, out_valid, out_id, out_bin);
      end
      @(negedge clk);
      req_valid[3] = 1'b0;
      #1;
      checks++;
      if ({req_ready, out_valid, out_id, out_bin} !== {4'b0010, 1'b1, 2'd3, 8'h80}) begin
         errors++; $display("FAIL bp_after_release: got rdy=%b v=%b id=%0d bin=%h expected rdy=0010 v=1 id=3 bin=80",
                            req_ready, out_valid, out_id, out_bin);
      end
      @(negedge clk);
      req_valid[1] = 1'b0;
      #1;
      checks++;
      if ({req_ready, out_valid, out_id, out_bin} !== {4'b0000, 1'b1, 2'd1, 8'h0A}) begin
         errors++; $display("FAIL bp_req1: got rdy=%b v=%b id=%0d bin=%h expected rdy=0000 v=1 id=1 bin=0a",
                            req_ready, out_valid, out_id, out_bin);
      end
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_drain: got v=%b expected 0", out_valid);
      end
   endtask

   task automatic test_fairness();
      // rr_ptr is 2 here; requesters 0 and 2 stay valid throughout.
      logic [1:0] exp_id;
      logic [7:0] exp_b;
      logic [3:0] exp_rdy;
      @(negedge clk);
      req_gray[7:0]   = 8'h03;
      req_gray[23:16] = 8'h06;
      req_valid = 4'b0101;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++; $display("FAIL fair_first: got %b expected 0100", req_ready);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         exp_id  = (i % 2 == 0) ? 2'd2 : 2'd0;
         exp_b   = (i % 2 == 0) ? 8'h04 : 8'h02;
         exp_rdy = (i % 2 == 0) ? 4'b0001 : 4'b0100;
         checks++;
         if ({out_valid, out_id, out_bin} !== {1'b1, exp_id, exp_b}) begin
            errors++; $display("FAIL fair_out_%0d: got v=%b id=%0d bin=%h expected v=1 id=%0d bin=%h",
                               i, out_valid, out_id, out_bin, exp_id, exp_b);
         end
         checks++;
         if (req_ready !== exp_rdy) begin
            errors++; $display("FAIL fair_ready_%0d: got %b expected %b", i, req_ready, exp_rdy);
         end
      end
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++;
      if ({out_valid, out_id, out_bin} !== {1'b1, 2'd2, 8'h04}) begin
         errors++; $display("FAIL fair_last: got v=%b id=%0d bin=%h expected v=1 id=2 bin=04",
                            out_valid, out_id, out_bin);
      end
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL fair_drain: got v=%b expected 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      // Requester 1 alone sweeps all 256 gray codes; code for n is n^(n>>1).
      logic [3:0] exp_rdy;
      @(negedge clk);
      req_gray[15:8] = 8'h00;
      req_valid = 4'b0010;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++; $display("FAIL b2b_first_ready: got %b expected 0010", req_ready);
      end
      for (int i = 1; i <= 256; i++) begin
         @(negedge clk);
         if (i < 256) req_gray[15:8] = 8'(i ^ (i >> 1));
         else         req_valid = '0;
         #1;
         exp_rdy = (i < 256) ? 4'b0010 : 4'b0000;
         checks++;
         if ({out_valid, out_id, out_bin} !== {1'b1, 2'd1, 8'(i - 1)}) begin
            errors++; $display("FAIL b2b_word_%0d: got v=%b id=%0d bin=%h expected v=1 id=1 bin=%h",
                               i - 1, out_valid, out_id, out_bin, 8'(i - 1));
         end
         checks++;
         if (req_ready !== exp_rdy) begin
            errors++; $display("FAIL b2b_ready_%0d: got %b expected %b", i, req_ready, exp_rdy);
         end
      end
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_drain: got v=%b expected 0", out_valid);
      end
   endtask

   task automatic test_wrap();
      // dut_b, NREQ=3: grays 0x01/0x0F/0x05 convert to 0x01/0x0A/0x06.
      logic [2:0] vld [7] = '{3'b010, 3'b011, 3'b010, 3'b100, 3'b111, 3'b110, 3'b000};
      logic [2:0] rdy [7] = '{3'b010, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b000};
      logic [1:0] oid [7] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
      logic [7:0] obn [7] = '{8'h00, 8'h0A, 8'h01, 8'h0A, 8'h06, 8'h01, 8'h0A};
      for (int s = 0; s < 7; s++) begin
         @(negedge clk);
         if (s == 0) req_gray_b = {8'h05, 8'h0F, 8'h01};
         req_valid_b = vld[s];
         #1;
         checks++;
         if (req_ready_b !== rdy[s]) begin
            errors++; $display("FAIL wrap_ready_%0d: got %b expected %b", s, req_ready_b, rdy[s]);
         end
         if (s > 0) begin
            checks++;
            if ({out_valid_b, out_id_b, out_bin_b} !== {1'b1, oid[s], obn[s]}) begin
               errors++; $display("FAIL wrap_out_%0d: got v=%b id=%0d bin=%h expected v=1 id=%0d bin=%h",
                                  s, out_valid_b, out_id_b, out_bin_b, oid[s], obn[s]);
            end
         end
      end
      @(negedge clk); #1;
      checks++;
      if (out_valid_b !== 1'b0) begin
         errors++; $display("FAIL wrap_drain: got v=%b expected 0", out_valid_b);
      end
   endtask

   initial begin
      test_reset();
      test_throughput();
      test_backpressure();
      test_fairness();
      test_back_to_back();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
